// File: rtl/axi2mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi2mem_arb_pkg
//   Shared types for the axi2mem transaction arbiter: the arbiter state
//   encoding and the 1-bit source tags stored in the per-lane tag FIFOs.
// -----------------------------------------------------------------------------
package axi2mem_arb_pkg;

  // IDLE_* states park priority on one channel. LOCK_* states hold a burst
  // until its last beat.
  typedef enum logic [1:0] {
    IDLE_PRI_RD = 2'd0,
    IDLE_PRI_WR = 2'd1,
    LOCK_RD     = 2'd2,
    LOCK_WR     = 2'd3
  } arb_state_e;

  // Source tag pushed per accepted lane request.
  localparam logic SRC_RD = 1'b0;
  localparam logic SRC_WR = 1'b1;

endpackage : axi2mem_arb_pkg

// File: rtl/axi2mem_tag_fifo.sv
// -----------------------------------------------------------------------------
// axi2mem_tag_fifo
//   In-order 1-bit FIFO that remembers which channel issued each outstanding
//   memory request on one lane.
//   Ports:
//     clk_i, rst_ni  clock, asynchronous active-low reset
//     push_i/data_i  enqueue one tag (ignored when full)
//     pop_i          dequeue the head tag (ignored when empty)
//     data_o         head tag
//     full_o/empty_o occupancy flags
// -----------------------------------------------------------------------------
module axi2mem_tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop_ok)  rptr_d = rptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: tag storage is left unreset; an entry is only read after it has
  // been written, because the count gates every pop.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule : axi2mem_tag_fifo

// File: rtl/axi2mem_trans_arbiter.sv
// -----------------------------------------------------------------------------
// axi2mem_trans_arbiter
//   Shares the two memory lanes between the axi2mem read and write channels.
//   Whole bursts are arbitrated round-robin (optionally locked to the last
//   beat); each accepted lane request pushes its source into a per-lane tag
//   FIFO so memory responses are routed back to the issuing channel.
//   Ports:
//     rd_*   read channel requests/grants/responses (2 lanes)
//     wr_*   write channel requests/grants/completions (2 lanes)
//     mem_*  memory-side request and response interface (2 lanes)
//     err_o  sticky: a response arrived with no outstanding request
// -----------------------------------------------------------------------------
module axi2mem_trans_arbiter
  import axi2mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned TAG_DEPTH  = 4,
  parameter bit          BURST_LOCK = 1'b1,
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  // read channel
  input  logic [1:0]                      rd_req_i,
  input  logic [1:0][ADDR_WIDTH-1:0]      rd_add_i,
  input  logic [1:0][ID_WIDTH-1:0]        rd_id_i,
  input  logic [1:0]                      rd_last_i,
  output logic [1:0]                      rd_gnt_o,
  output logic [1:0]                      rd_rvalid_o,
  output logic [1:0][DATA_WIDTH-1:0]      rd_rdata_o,
  // write channel
  input  logic [1:0]                      wr_req_i,
  input  logic [1:0][ADDR_WIDTH-1:0]      wr_add_i,
  input  logic [1:0][ID_WIDTH-1:0]        wr_id_i,
  input  logic [1:0]                      wr_last_i,
  input  logic [1:0][DATA_WIDTH-1:0]      wr_wdata_i,
  input  logic [1:0][BE_WIDTH-1:0]        wr_be_i,
  output logic [1:0]                      wr_gnt_o,
  output logic [1:0]                      wr_rvalid_o,
  // memory side
  output logic [1:0]                      mem_req_o,
  output logic [1:0][ADDR_WIDTH-1:0]      mem_add_o,
  output logic [1:0]                      mem_we_o,
  output logic [1:0][DATA_WIDTH-1:0]      mem_wdata_o,
  output logic [1:0][BE_WIDTH-1:0]        mem_be_o,
  output logic [1:0][ID_WIDTH-1:0]        mem_id_o,
  input  logic [1:0]                      mem_gnt_i,
  input  logic [1:0]                      mem_rvalid_i,
  input  logic [1:0][DATA_WIDTH-1:0]      mem_rdata_i,
  output logic                            err_o
);

  arb_state_e state_q, state_d;
  logic       sel_wr, ok, accept, sel_last;
  logic [1:0] sel_req, full, empty, head, push, pop;
  logic       err_q, err_d;

  // Requesters drive both lanes identically; only lane 0 steers the FSM.
  logic unused_lane1_last;
  assign unused_lane1_last = rd_last_i[1] ^ wr_last_i[1];

  assign sel_wr   = (state_q == IDLE_PRI_WR) || (state_q == LOCK_WR);
  assign sel_req  = sel_wr ? wr_req_i : rd_req_i;
  assign sel_last = sel_wr ? wr_last_i[0] : rd_last_i[0];

  // Grants never look at *_req_i, so a requester waiting for gnt before
  // raising req cannot close a combinational loop through this block.
  assign ok       = (&mem_gnt_i) & ~full[0] & ~full[1];
  assign rd_gnt_o = sel_wr ? 2'b00 : {ok, ok};
  assign wr_gnt_o = sel_wr ? {ok, ok} : 2'b00;
  assign accept   = sel_req[0] & ok;

  // Memory-side mux: zero latency pass-through of the selected channel.
  assign mem_req_o   = sel_req & {ok, ok};
  assign mem_add_o   = sel_wr ? wr_add_i : rd_add_i;
  assign mem_id_o    = sel_wr ? wr_id_i : rd_id_i;
  assign mem_we_o    = {2{sel_wr}};
  assign mem_wdata_o = sel_wr ? wr_wdata_i : '0;
  assign mem_be_o    = sel_wr ? wr_be_i : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_PRI_RD: begin
        // An idle cycle hands priority over so the other side waits <= 1 cycle.
        if (!rd_req_i[0])  state_d = IDLE_PRI_WR;
        else if (accept)   state_d = (rd_last_i[0] || !BURST_LOCK) ? IDLE_PRI_WR : LOCK_RD;
      end
      IDLE_PRI_WR: begin
        if (!wr_req_i[0])  state_d = IDLE_PRI_RD;
        else if (accept)   state_d = (wr_last_i[0] || !BURST_LOCK) ? IDLE_PRI_RD : LOCK_WR;
      end
      LOCK_RD:     if (accept && sel_last) state_d = IDLE_PRI_WR;
      LOCK_WR:     if (accept && sel_last) state_d = IDLE_PRI_RD;
      default:     state_d = IDLE_PRI_RD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE_PRI_RD;
    else         state_q <= state_d;
  end

  // Per-lane source tracking. A response with an empty FIFO is dropped even
  // if a push happens the same cycle: memory latency is at least one cycle,
  // so such a response cannot belong to that request.
  for (genvar b = 0; b < 2; b++) begin : g_lane
    assign push[b] = mem_req_o[b] & mem_gnt_i[b];
    assign pop[b]  = mem_rvalid_i[b] & ~empty[b];

    axi2mem_tag_fifo #(
      .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push[b]),
      .data_i  (sel_wr ? SRC_WR : SRC_RD),
      .pop_i   (pop[b]),
      .data_o  (head[b]),
      .full_o  (full[b]),
      .empty_o (empty[b])
    );

    assign rd_rvalid_o[b] = pop[b] & (head[b] == SRC_RD);
    assign wr_rvalid_o[b] = pop[b] & (head[b] == SRC_WR);
  end

  assign rd_rdata_o = mem_rdata_i;

  assign err_d = err_q | (|(mem_rvalid_i & empty));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;

endmodule : axi2mem_trans_arbiter

// File: doc/axi2mem_trans_arbiter.md
Name: axi2mem_trans_arbiter

Overview:
Shares the two 32-bit memory lanes (bank 0 / bank 1 pair) between the axi2mem read-channel and write-channel transaction ports. Arbitrates whole bursts round-robin and locks a burst until its last beat. Tracks the source of every accepted lane request in a per-lane in-order tag FIFO, and routes memory read-valid back to the correct channel. Sits between axi2mem_rd_channel/axi2mem_wr_channel and the memory-side request/response interface.

Parameters:
ADDR_WIDTH, 32, per-lane address width
DATA_WIDTH, 32, per-lane data width; BE width = DATA_WIDTH/8
ID_WIDTH, 6, transaction id width
TAG_DEPTH, 4, entries per lane tag FIFO (power of 2, >=2)
BURST_LOCK, 1, 1 = hold ownership until last beat; 0 = re-arbitrate every beat

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
rd_req_i  in  2  read channel lane requests
rd_add_i  in  2xADDR_WIDTH  read lane addresses
rd_id_i  in  2xID_WIDTH  read lane ids
rd_last_i  in  2  read last beat
rd_gnt_o  out  2  grant to read channel
rd_rvalid_o  out  2  read data valid per lane
rd_rdata_o  out  2xDATA_WIDTH  read data per lane
wr_req_i  in  2  write channel lane requests
wr_add_i  in  2xADDR_WIDTH  write lane addresses
wr_id_i  in  2xID_WIDTH  write lane ids
wr_last_i  in  2  write last beat
wr_wdata_i  in  2xDATA_WIDTH  write data
wr_be_i  in  2xBE_WIDTH  write byte enables
wr_gnt_o  out  2  grant to write channel
wr_rvalid_o  out  2  write completion per lane
mem_req_o  out  2  memory lane requests
mem_add_o  out  2xADDR_WIDTH  memory addresses
mem_we_o  out  2  write enable (1 = write)
mem_wdata_o  out  2xDATA_WIDTH  write data
mem_be_o  out  2xBE_WIDTH  byte enables
mem_id_o  out  2xID_WIDTH  ids
mem_gnt_i  in  2  memory lane ready
mem_rvalid_i  in  2  memory response valid per lane
mem_rdata_i  in  2xDATA_WIDTH  memory response data
err_o  out  1  sticky protocol error

Behaviour:
- Reset: FSM = IDLE_PRI_RD; tag FIFOs empty; err_o = 0. All gnt/req/rvalid outputs are 0 while no condition asserts them.
- Requesters drive both lane bits identically. The FSM acts on lane 0; lane mismatch is a bench assertion, not RTL-checked.
- Grant rule: gnt outputs are functions of FSM state, mem_gnt_i and FIFO full flags only. They never depend on any *_req_i, so no combinational loop forms with requesters that wait for gnt before raising req.
- Grant offer: ok = mem_gnt_i==2'b11 && !full[0] && !full[1]. Only the selected requester receives gnt = {ok,ok}; the other receives 2'b00.
- Selection: IDLE_PRI_RD and LOCK_RD select rd; IDLE_PRI_WR and LOCK_WR select wr.
- Accept = selected req[0] & gnt[0].
- IDLE_PRI_RD:
  - accept & last[0] -> IDLE_PRI_WR.
  - accept & !last & BURST_LOCK -> LOCK_RD.
  - accept & !last & !BURST_LOCK -> IDLE_PRI_WR.
  - no req -> IDLE_PRI_WR (parking toggle; costs at most 1 cycle latency).
  - req but !ok -> stay.
- IDLE_PRI_WR: symmetric, with rd/wr swapped.
- LOCK_RD: accept & last -> IDLE_PRI_WR; otherwise stay, regardless of wr requests. LOCK_WR: symmetric.
- Mem mux (combinational, zero latency):
  - mem_req_o = selected req & gnt.
  - mem_add/id come from the selected requester.
  - mem_we_o = 1 only when wr is selected.
  - mem_wdata/be come from wr when selected, else 0.
- Tag FIFO, per lane: on mem_req_o[b]&mem_gnt_i[b], push 1 bit (1 = wr). On mem_rvalid_i[b], pop.
  - rd_rvalid_o[b] = mem_rvalid_i[b] & head==0.
  - wr_rvalid_o[b] = mem_rvalid_i[b] & head==1.
  - rd_rdata_o = mem_rdata_i (unregistered broadcast).
- Full: no gnt is offered. Pop while full is legal, and the next cycle is no longer full.
- Response on an empty FIFO, even with a same-cycle push (memory latency >=1): response is dropped, no rvalid, err_o set until reset.
- Pointers wrap modulo TAG_DEPTH; count width is clog2(TAG_DEPTH)+1.
- Reset mid-burst: the FSM returns to IDLE_PRI_RD and FIFOs clear. In-flight responses after reset raise err_o.

Decomposition:
- Package axi2mem_arb_pkg: state enum {IDLE_PRI_RD, IDLE_PRI_WR, LOCK_RD, LOCK_WR}; SRC_RD=1'b0 / SRC_WR=1'b1 constants.
- Sub-module axi2mem_tag_fifo (1-bit, depth TAG_DEPTH, full/empty outputs), instantiated once per lane.

Test Plan:
- Single rd beat: rd_req=11, last=11, mem_gnt=11, add=0x100 -> mem_req=11, add {0x100,0x104}, we=00; one cycle later mem_rvalid=11 -> rd_rvalid=11, wr_rvalid=00; state -> IDLE_PRI_WR.
- Burst lock: rd 4-beat burst with wr_req held high -> 4 consecutive rd accepts, wr_gnt=00 throughout, wr granted the cycle after rd's last beat.
- Round-robin: rd and wr both issue continuous single beats -> grants alternate rd, wr, rd, wr; mem_we toggles 0,1,0,1.
- Backpressure: hold mem_rvalid=0 and issue 4 rd beats (TAG_DEPTH=4) -> 5th gnt=00; one mem_rvalid=11 -> gnt offered next cycle.
- Ordering: wr beat then rd beat accepted, responses returned in order -> first response wr_rvalid=11, second rd_rvalid=11.
- Error: mem_rvalid=01 with empty FIFOs -> no rvalid out, err_o=1 until rst_ni low.
